// File: rtl/game_input_sequencer_if.sv
// Key levels from the PS2 side and game status/position outputs toward processor and VGA.
// The sequencer is the slave; the keyboard/processor side (or a bench) is the master.
interface game_input_sequencer_if;
    logic        move_left;
    logic        move_right;
    logic        fire;
    logic        pause;
    logic        game_over_in;
    logic        game_status;
    logic        paused;
    logic [1:0]  state;
    logic [31:0] spaceship_x;
    logic        fire_pulse;
    logic        tick;

    modport master (
        output move_left, move_right, fire, pause, game_over_in,
        input  game_status, paused, state, spaceship_x, fire_pulse, tick
    );

    modport slave (
        input  move_left, move_right, fire, pause, game_over_in,
        output game_status, paused, state, spaceship_x, fire_pulse, tick
    );
endinterface

// File: rtl/game_input_sequencer.sv
// Turns held PS2 key levels into tick-paced ship movement, rate-limited shots and the
// IDLE/PLAY/PAUSE/OVER game state; sole owner of game_status.
module game_input_sequencer #(
    parameter int TICK_DIV      = 500000,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 600,
    parameter int X_START       = 300,
    parameter int STEP          = 4,
    parameter int FIRE_COOLDOWN = 25
) (
    input  logic                   clock,
    input  logic                   resetn,
    game_input_sequencer_if.slave  bus
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CD_W  = $clog2(FIRE_COOLDOWN + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]      r_x, w_x_nxt;
    logic [CD_W-1:0] r_cd, w_cd_nxt;
    logic            r_fire_q, r_pause_q;
    logic            r_fire_pulse, w_fire_pulse_nxt;
    logic            r_tick;

    logic w_tick_now, w_pause_rise, w_fire_rise, w_go_left, w_go_right;

    assign w_tick_now   = (r_cnt == CNT_W'(TICK_DIV - 1));
    assign w_pause_rise = bus.pause & ~r_pause_q;
    assign w_fire_rise  = bus.fire & ~r_fire_q;
    assign w_go_left    = bus.move_left & ~bus.move_right;
    assign w_go_right   = bus.move_right & ~bus.move_left;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_x          <= 10'(X_START);
            r_cd         <= '0;
            r_fire_pulse <= 1'b0;
            r_tick       <= 1'b0;
            r_fire_q     <= 1'b1;
            r_pause_q    <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_tick_now ? '0 : r_cnt + CNT_W'(1);
            r_x          <= w_x_nxt;
            r_cd         <= w_cd_nxt;
            r_fire_pulse <= w_fire_pulse_nxt;
            r_tick       <= w_tick_now;
            r_fire_q     <= bus.fire;
            r_pause_q    <= bus.pause;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_x_nxt          = r_x;
        w_cd_nxt         = r_cd;
        w_fire_pulse_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pause_rise) begin
                    w_state_nxt = S_PLAY;
                    w_x_nxt     = 10'(X_START);
                    w_cd_nxt    = '0;
                end
            end
            S_PLAY: begin
                // Clamp rather than wrap: compare before stepping so unsigned x never underflows.
                if (w_tick_now && w_go_left)
                    w_x_nxt = (r_x < 10'(X_MIN + STEP)) ? 10'(X_MIN) : r_x - 10'(STEP);
                else if (w_tick_now && w_go_right)
                    w_x_nxt = (r_x > 10'(X_MAX - STEP)) ? 10'(X_MAX) : r_x + 10'(STEP);

                // A shot is judged on the pre-decrement cooldown, and its reload beats the tick.
                if (w_fire_rise && (r_cd == '0)) begin
                    w_fire_pulse_nxt = 1'b1;
                    w_cd_nxt         = CD_W'(FIRE_COOLDOWN);
                end else if (w_tick_now && (r_cd != '0)) begin
                    w_cd_nxt = r_cd - CD_W'(1);
                end

                if (bus.game_over_in)
                    w_state_nxt = S_OVER;
                else if (w_pause_rise)
                    w_state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (w_pause_rise)
                    w_state_nxt = S_PLAY;
            end
            S_OVER: begin
                if (w_pause_rise)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.state       = r_state;
    assign bus.game_status = (r_state == S_PLAY);
    assign bus.paused      = (r_state == S_PAUSE);
    assign bus.spaceship_x = {22'd0, r_x};
    assign bus.fire_pulse  = r_fire_pulse;
    assign bus.tick        = r_tick;

endmodule
